// File: rtl/dram_unit.sv
// 1024-byte byte-addressed memory with combinational big-endian field reads.
// Asynchronous reset clears the whole array; writes are one byte per clock.
module dram_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  ADDR,
    input  logic [1:0]  DATA_SEL,
    input  logic [7:0]  DATA_WRITE,
    input  logic        MW,
    output logic [11:0] DATA_LOW_12BIT,
    output logic [19:0] DATA_UPPER_20BIT,
    output logic [7:0]  DATA_BYTE
);

    localparam int DEPTH = 1024;

    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [9:0]  addr1_s;
    logic [9:0]  addr2_s;
    logic [9:0]  addr3_s;
    logic [31:0] word_s;

    // Next-state of the array: only the addressed byte changes, and only on MW.
    always_comb begin
        mem_d = mem_q;
        if (MW == 1'b1) begin
            mem_d[ADDR] = DATA_WRITE;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // 10-bit arithmetic wraps the word past the top of the array back to 0.
    assign addr1_s = ADDR + 10'd1;
    assign addr2_s = ADDR + 10'd2;
    assign addr3_s = ADDR + 10'd3;
    assign word_s  = {mem_q[ADDR], mem_q[addr1_s], mem_q[addr2_s], mem_q[addr3_s]};

    // Read-format decode; unselected fields are held at zero.
    always_comb begin
        DATA_LOW_12BIT   = 12'h000;
        DATA_UPPER_20BIT = 20'h00000;
        DATA_BYTE        = 8'h00;
        case (DATA_SEL)
            2'b00:   DATA_LOW_12BIT   = word_s[31:20];
            2'b01:   DATA_UPPER_20BIT = word_s[19:0];
            2'b10:   DATA_BYTE        = word_s[31:24];
            default: begin
                DATA_LOW_12BIT   = 12'h000;
                DATA_UPPER_20BIT = 20'h00000;
                DATA_BYTE        = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_dram_unit.sv
// Self-checking bench for dram_unit: directed cases plus randomized traffic
// compared against a byte-array reference model.
module tb_dram_unit;

    logic        CLK;
    logic        RST;
    logic [9:0]  ADDR;
    logic [1:0]  DATA_SEL;
    logic [7:0]  DATA_WRITE;
    logic        MW;
    logic [11:0] DATA_LOW_12BIT;
    logic [19:0] DATA_UPPER_20BIT;
    logic [7:0]  DATA_BYTE;

    int checks;
    int failures;
    logic [7:0] model [1024];

    dram_unit dut (
        .CLK              (CLK),
        .RST              (RST),
        .ADDR             (ADDR),
        .DATA_SEL         (DATA_SEL),
        .DATA_WRITE       (DATA_WRITE),
        .MW               (MW),
        .DATA_LOW_12BIT   (DATA_LOW_12BIT),
        .DATA_UPPER_20BIT (DATA_UPPER_20BIT),
        .DATA_BYTE        (DATA_BYTE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {model[a % 1024], model[(a + 1) % 1024], model[(a + 2) % 1024], model[(a + 3) % 1024]};
    endfunction

    // Compare all three outputs against the model for the current ADDR/DATA_SEL.
    task automatic check_outputs(input string tag);
        logic [31:0] w;
        logic [31:0] e12;
        logic [31:0] e20;
        logic [31:0] e8;
        w   = model_word(int'(ADDR));
        e12 = (DATA_SEL == 2'b00) ? (w >> 20) : 32'd0;
        e20 = (DATA_SEL == 2'b01) ? (w % 32'h100000) : 32'd0;
        e8  = (DATA_SEL == 2'b10) ? (w >> 24) : 32'd0;
        check({tag, ".low12"}, {20'd0, DATA_LOW_12BIT}, e12);
        check({tag, ".up20"}, {12'd0, DATA_UPPER_20BIT}, e20);
        check({tag, ".byte"}, {24'd0, DATA_BYTE}, e8);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR       = a;
        DATA_WRITE = d;
        MW         = 1'b1;
        @(posedge CLK);
        model[a] = d;
        #1;
        MW = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, input logic [1:0] sel, input string tag);
        @(negedge CLK);
        MW       = 1'b0;
        ADDR     = a;
        DATA_SEL = sel;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        RST        = 1'b1;
        MW         = 1'b0;
        ADDR       = 10'd0;
        DATA_SEL   = 2'b10;
        DATA_WRITE = 8'h00;
        #1;
        check_outputs("rst_byte");
        DATA_SEL = 2'b00;
        #1;
        check_outputs("rst_low12");
        @(negedge CLK);
        RST = 1'b0;

        // Alternating pattern at 0..3.
        do_write(10'd0, 8'hFF);
        do_write(10'd1, 8'h00);
        do_write(10'd2, 8'hFF);
        do_write(10'd3, 8'h00);
        do_read(10'd0, 2'b00, "pat_low12");
        check("pat_low12_const", {20'd0, DATA_LOW_12BIT}, 32'h0000_0FF0);
        do_read(10'd0, 2'b01, "pat_up20");
        check("pat_up20_const", {12'd0, DATA_UPPER_20BIT}, 32'h0000_FF00);
        do_read(10'd0, 2'b10, "pat_byte");
        check("pat_byte_const", {24'd0, DATA_BYTE}, 32'h0000_00FF);

        // Wrap-around word spanning the top of the array.
        do_write(10'd1022, 8'h12);
        do_write(10'd1023, 8'h34);
        do_write(10'd0, 8'h56);
        do_write(10'd1, 8'h78);
        do_read(10'd1022, 2'b00, "wrap_low12");
        check("wrap_low12_const", {20'd0, DATA_LOW_12BIT}, 32'h0000_0123);
        do_read(10'd1022, 2'b01, "wrap_up20");
        check("wrap_up20_const", {12'd0, DATA_UPPER_20BIT}, 32'h0004_5678);
        do_read(10'd1022, 2'b11, "wrap_none");

        // Same-cycle write and read: old data before the edge, new after.
        @(negedge CLK);
        ADDR       = 10'd1022;
        DATA_SEL   = 2'b10;
        DATA_WRITE = 8'hA5;
        MW         = 1'b1;
        #1;
        check_outputs("rw_before");
        @(posedge CLK);
        model[1022] = 8'hA5;
        #1;
        MW = 1'b0;
        check_outputs("rw_after");

        // Unknown data/select with MW low must not disturb memory.
        @(negedge CLK);
        ADDR       = 10'd1022;
        DATA_WRITE = 8'hxx;
        DATA_SEL   = 2'bxx;
        MW         = 1'b0;
        @(posedge CLK);
        #1;
        DATA_SEL = 2'b00;
        #1;
        check_outputs("x_hold");

        // Randomized traffic, biased toward the wrap region.
        for (int n = 0; n < 300; n++) begin
            logic [9:0] a;
            a = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, 8'($urandom_range(0, 255)));
            end else begin
                do_read(a, 2'($urandom_range(0, 3)), "rand");
            end
        end

        // Reset asserted between edges in the middle of a write burst.
        do_write(10'd10, 8'h3C);
        do_write(10'd11, 8'hC3);
        @(negedge CLK);
        ADDR       = 10'd12;
        DATA_WRITE = 8'h99;
        MW         = 1'b1;
        #2;
        RST = 1'b1;
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        #1;
        DATA_SEL = 2'b10;
        ADDR     = 10'd10;
        #1;
        check_outputs("async_rst_immediate");
        ADDR = 10'd12;
        @(posedge CLK);
        #1;
        check_outputs("rst_blocks_write");
        DATA_SEL = 2'b01;
        #1;
        check_outputs("rst_up20");
        @(negedge CLK);
        MW  = 1'b0;
        RST = 1'b0;
        DATA_SEL = 2'b10;
        for (int i = 0; i < 1024; i++) begin
            ADDR = 10'(i);
            #1;
            check_outputs("sweep_zero");
        end

        // First write after reset release lands normally.
        do_write(10'd12, 8'h5A);
        do_read(10'd12, 2'b10, "post_rst_write");
        check("post_rst_const", {24'd0, DATA_BYTE}, 32'h0000_005A);
        do_read(10'd11, 2'b00, "post_rst_low12");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_unit.md
DRAM_UNIT -- requirements
Module: dram

Interface
REQ-001 CLK  input  1  — single system clock; all state updates on rising edge.
REQ-002 RST  input  1  — reset, asynchronous, active-high.
REQ-003 ADDR  input  10  — byte address A into a 1024-byte array.
REQ-004 DATA_SEL  input  2  — read-format select: 00 = 12-bit field, 01 = 20-bit field, 10 = byte, 11 = none.
REQ-005 DATA_WRITE  input  8  — write data byte.
REQ-006 MW  input  1  — memory write enable, active-high.
REQ-007 DATA_LOW_12BIT  output  12  — 12-bit read field.
REQ-008 DATA_UPPER_20BIT  output  20  — 20-bit read field.
REQ-009 DATA_BYTE  output  8  — byte read field.

Function
REQ-010 Storage SHALL be 1024 bytes, M[0..1023], byte-addressed by ADDR.
REQ-011 On rising CLK with MW=1 and RST=0, M[ADDR] SHALL take DATA_WRITE; DATA_SEL ignored for writes; one byte per cycle.
REQ-012 With MW=0, M SHALL hold its contents.
REQ-013 Read word W SHALL be big-endian: W[31:0] = {M[A], M[A+1], M[A+2], M[A+3]}, indices taken modulo 1024 (A=1022 reads M[1022], M[1023], M[0], M[1]).
REQ-014 DATA_LOW_12BIT SHALL equal W[31:20] = {M[A], M[A+1][7:4]} when DATA_SEL=00, else 0.
REQ-015 DATA_UPPER_20BIT SHALL equal W[19:0] = {M[A+1][3:0], M[A+2], M[A+3]} when DATA_SEL=01, else 0.
REQ-016 DATA_BYTE SHALL equal M[A] when DATA_SEL=10, else 0.
REQ-017 DATA_SEL=11 SHALL drive all three outputs to 0.
REQ-018 Reads SHALL be combinational (zero-cycle latency) from ADDR, DATA_SEL and current M; no read enable.
REQ-019 Simultaneous write and read SHALL show pre-edge data before the edge and newly written data after the edge (no internal bypass).
REQ-020 X/Z on DATA_SEL or DATA_WRITE while MW=0 SHALL not alter M.

Reset
REQ-021 RST=1 SHALL immediately, independent of CLK, clear every M byte to 0x00.
REQ-022 While RST=1, writes SHALL be blocked; outputs SHALL reflect zeroed memory per REQ-014..017.
REQ-023 Reset asserted mid-sequence SHALL discard all prior writes; after deassertion, the first rising edge with MW=1 SHALL write normally.

Verification
REQ-024 Reset, then DATA_SEL=10, ADDR=0x000 -> DATA_BYTE=0x00; DATA_SEL=00 -> DATA_LOW_12BIT=0x000.
REQ-025 Write 0xFF, 0x00, 0xFF, 0x00 to addresses 0..3 (MW=1, one per clock); then MW=0, ADDR=0, DATA_SEL=00 -> DATA_LOW_12BIT=0xFF0 (0b111111110000).
REQ-026 Same contents, DATA_SEL=01 -> DATA_UPPER_20BIT=0x0FF00; DATA_SEL=10 -> DATA_BYTE=0xFF; other two outputs 0 in each case.
REQ-027 Write 0x12, 0x34, 0x56, 0x78 to addresses 1022, 1023, 0, 1; ADDR=1022: DATA_SEL=00 -> 0x123, DATA_SEL=01 -> 0x45678 (wrap-around).
REQ-028 DATA_SEL=11 after any writes -> all outputs 0; assert RST mid-write-burst, clock-independent -> every address reads 0x00, the in-flight write is not stored.
